// File: rtl/reset_pulse_sequencer.sv
// Staged reset release sequencer: holds all outputs in reset, then
// releases them one stage at a time with a fixed gap between stages.
module reset_pulse_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int STAGES       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              hold,
  output logic [STAGES-1:0] reset_out,
  output logic              busy,
  output logic              done
);

  localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam int IW   = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(STAGES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STAGES-1:0] rout_q, rout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State, timer, stage index and all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ASSERT;
      timer_q <= '0;
      idx_q   <= '0;
      rout_q  <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      rout_q  <= rout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: a request or hold restarts the whole timeline,
  // otherwise the timer walks through the pulse and each release gap.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    rout_d  = rout_q;
    done_d  = 1'b0;
    if (req || hold) begin
      state_d = ASSERT;
      timer_d = '0;
      idx_d   = '0;
      rout_d  = '1;
    end else begin
      unique case (state_q)
        IDLE: begin
          rout_d  = '0;
          timer_d = '0;
          idx_d   = '0;
        end
        ASSERT: begin
          if (timer_q == P_LAST) begin
            timer_d = '0;
            rout_d  = rout_q << 1;
            if (STAGES == 1) begin
              done_d  = 1'b1;
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              state_d = RELEASE;
              idx_d   = IW'(1);
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        RELEASE: begin
          if (timer_q == G_LAST) begin
            timer_d = '0;
            rout_d  = rout_q << 1;
            if (idx_q == I_LAST) begin
              done_d  = 1'b1;
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          idx_d   = '0;
          rout_d  = '0;
        end
      endcase
    end
    busy_d = |rout_d;
  end

  assign reset_out = rout_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reset_pulse_sequencer.sv
// Self-checking bench for reset_pulse_sequencer against an
// edges-since-last-start reference model.
module tb_reset_pulse_sequencer;

  localparam int P  = 4;
  localparam int G  = 2;
  localparam int ST = 3;
  localparam int DONE_AT = P + (ST - 1) * G;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          hold = 1'b0;
  logic [ST-1:0] reset_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int since = 0;
  int ndone = 0;

  always #5 clk = ~clk;

  reset_pulse_sequencer #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES(G),
    .STAGES(ST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .hold(hold),
    .reset_out(reset_out),
    .busy(busy),
    .done(done)
  );

  function automatic logic [ST-1:0] exp_out(input int s);
    logic [ST-1:0] e;
    for (int k = 0; k < ST; k++) e[k] = (s < P + k * G);
    return e;
  endfunction

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic tick(input logic r, input logic h);
    req = r;
    hold = h;
    @(posedge clk);
    #1;
    if (r || h) since = 0;
    else if (since < 1000) since++;
    if (done) ndone++;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (reset_out !== 3'b111 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL in_reset got=%b/%b/%b want=111/1/0", reset_out, busy, done);
    end
    reset = 1'b0;
    since = 0;
    for (int e = 1; e <= 9; e++) begin
      tick(1'b0, 1'b0);
      if (e == 3 || e == 4 || e == 6 || e == 8) begin
        logic [ST-1:0] w;
        w = (e == 3) ? 3'b111 : (e == 4) ? 3'b110 : (e == 6) ? 3'b100 : 3'b000;
        checks++;
        if (reset_out !== w || done !== (e == 8)) begin
          failures++;
          $display("FAIL powerup_e%0d got=%b/%b want=%b/%b", e, reset_out, done, w, e == 8);
        end
      end
      if (e == 9) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL powerup_e9 got done=%b busy=%b want 0/0", done, busy);
        end
      end
    end
  endtask

  task automatic test_idle_req;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    checks++;
    if (reset_out !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle got=%b/%b/%b want=000/0/0", reset_out, busy, done);
    end
    tick(1'b1, 1'b0);
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) tick(1'b0, 1'b0);
      checks++;
      if (reset_out !== exp_out(since) || busy !== (|exp_out(since)) ||
          done !== (since == DONE_AT)) begin
        failures++;
        $display("FAIL idle_req_t%0d got=%b/%b/%b want=%b/%b/%b", i, reset_out,
                 busy, done, exp_out(since), |exp_out(since), since == DONE_AT);
      end
    end
  endtask

  task automatic test_restart;
    ndone = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < P; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (reset_out !== 3'b111 || done !== 1'b0) begin
      failures++;
      $display("FAIL restart got=%b/%b want=111/0", reset_out, done);
    end
    for (int i = 1; i <= DONE_AT + 3; i++) begin
      tick(1'b0, 1'b0);
      if (i == P) begin
        checks++;
        if (reset_out !== 3'b110) begin
          failures++;
          $display("FAIL restart_110 got=%b want=110", reset_out);
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL restart_done_count got=%0d want=1", ndone);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (reset_out !== 3'b111 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL hold_t%0d got=%b/%b/%b want=111/1/0", i, reset_out, busy, done);
      end
    end
    for (int i = 1; i <= DONE_AT; i++) begin
      tick(1'b0, 1'b0);
      if (i == P || i == DONE_AT) begin
        checks++;
        if (reset_out !== exp_out(i) || done !== (i == DONE_AT)) begin
          failures++;
          $display("FAIL hold_after_%0d got=%b/%b want=%b/%b", i, reset_out, done,
                   exp_out(i), i == DONE_AT);
        end
      end
    end
  endtask

  task automatic test_collision;
    ndone = 0;
    tick(1'b1, 1'b0);
    for (int i = 1; i < DONE_AT; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (reset_out !== 3'b111 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL collision got=%b/%b/%b want=111/0/1", reset_out, done, busy);
    end
    for (int i = 1; i <= DONE_AT + 2; i++) tick(1'b0, 1'b0);
    checks++;
    if (ndone !== 1 || reset_out !== 3'b000) begin
      failures++;
      $display("FAIL collision_end got done_count=%0d out=%b want 1/000", ndone, reset_out);
    end
  endtask

  task automatic test_async_reset;
    tick(1'b1, 1'b0);
    for (int i = 1; i <= P + G; i++) tick(1'b0, 1'b0);
    checks++;
    if (reset_out !== 3'b100) begin
      failures++;
      $display("FAIL async_pre got=%b want=100", reset_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (reset_out !== 3'b111 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%b/%b/%b want=111/1/0", reset_out, busy, done);
    end
    #1 reset = 1'b0;
    since = 0;
    for (int i = 1; i <= DONE_AT + 1; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (reset_out !== exp_out(since) || done !== (since == DONE_AT)) begin
        failures++;
        $display("FAIL async_seq_e%0d got=%b/%b want=%b/%b", i, reset_out, done,
                 exp_out(since), since == DONE_AT);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic h;
      r = ($urandom_range(0, 11) == 0);
      h = ($urandom_range(0, 15) == 0);
      tick(r, h);
      checks++;
      if (reset_out !== exp_out(since) || busy !== (|exp_out(since)) ||
          done !== (since == DONE_AT)) begin
        failures++;
        $display("FAIL random_t%0d got=%b/%b/%b want=%b/%b/%b", i, reset_out, busy,
                 done, exp_out(since), |exp_out(since), since == DONE_AT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_req();
    test_restart();
    test_hold();
    test_collision();
    test_async_reset();
    test_random();
    req = 1'b0;
    hold = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
